// File: rtl/qa_driver_sreg_ctrl.sv
// ============================================================================
// qa_driver_sreg_ctrl : CSR-triggered status-register read, result pushed to DSM.
// Optional WAIT timeout: define QA_SREG_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module qa_driver_sreg_ctrl #(
  parameter int unsigned SREG_TIMEOUT    = 1024,
  parameter logic [63:0] DSM_SREG_OFFSET = 64'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_wr_valid,
  input  logic [15:0] csr_wr_addr,
  input  logic [63:0] csr_wr_data,
  output logic        sreg_req_valid,
  output logic [31:0] sreg_req_addr,
  input  logic        sreg_req_ready,
  input  logic        sreg_rsp_valid,
  input  logic [63:0] sreg_rsp_data,
  output logic        dsm_wr_valid,
  output logic [63:0] dsm_wr_addr,
  output logic [63:0] dsm_wr_data,
  input  logic        dsm_wr_ready,
  output logic        dsm_base_valid,
  output logic        busy,
  output logic        drop_flag,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  if (SREG_TIMEOUT < 2 || SREG_TIMEOUT > 65535) begin : g_bad_timeout
    $error("SREG_TIMEOUT out of range 2..65535");
  end

  state_t      state_q, state_d;
  logic [63:0] base_q, base_d;
  logic        base_valid_q, base_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        drop_q, drop_d;
  logic        req_valid_q, req_valid_d;
  logic        wr_valid_q, wr_valid_d;
  logic        busy_q, busy_d;
  logic        wr_base, wr_go;

`ifdef QA_SREG_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(SREG_TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign wr_base = csr_wr_valid && (csr_wr_addr == 16'h1a00);
  assign wr_go   = csr_wr_valid && (csr_wr_addr == 16'h1a10);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    base_valid_d = base_valid_q;
    req_addr_d   = req_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    drop_d       = drop_q;
`ifdef QA_SREG_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
`endif

    if (wr_base) begin
      base_d       = csr_wr_data;
      base_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_go) begin
          if (base_valid_q) begin
            // Result address is fixed at accept time so later base writes cannot move it.
            req_addr_d = csr_wr_data[31:0];
            wr_addr_d  = base_q + DSM_SREG_OFFSET;
            state_d    = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (sreg_req_ready) begin
          state_d = S_WAIT;
`ifdef QA_SREG_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      S_WAIT: begin
        if (sreg_rsp_valid) begin
          wr_data_d = sreg_rsp_data;
          state_d   = S_WRITE;
        end
`ifdef QA_SREG_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          wr_data_d = '1;
          timeout_d = 1'b1;
          state_d   = S_WRITE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_WRITE: begin
        if (dsm_wr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_go && state_q != S_IDLE) drop_d = 1'b1;

    req_valid_d = (state_d == S_REQ);
    wr_valid_d  = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      base_valid_q <= 1'b0;
      req_addr_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef QA_SREG_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      base_valid_q <= base_valid_d;
      req_addr_q   <= req_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      wr_valid_q   <= wr_valid_d;
      busy_q       <= busy_d;
`ifdef QA_SREG_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign sreg_req_valid = req_valid_q;
  assign sreg_req_addr  = req_addr_q;
  assign dsm_wr_valid   = wr_valid_q;
  assign dsm_wr_addr    = wr_addr_q;
  assign dsm_wr_data    = wr_data_q;
  assign dsm_base_valid = base_valid_q;
  assign busy           = busy_q;
  assign drop_flag      = drop_q;
`ifdef QA_SREG_TIMEOUT_EN
  assign timeout_flag   = timeout_q;
`else
  assign timeout_flag   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qa_driver_sreg_ctrl.sv
// ============================================================================
// tb_qa_driver_sreg_ctrl : randomized transactions against a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_qa_driver_sreg_ctrl;

  localparam logic [63:0] OFF = 64'h40;
  localparam int          TO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_wr_valid;
  logic [15:0] csr_wr_addr;
  logic [63:0] csr_wr_data;
  logic        sreg_req_valid;
  logic [31:0] sreg_req_addr;
  logic        sreg_req_ready;
  logic        sreg_rsp_valid;
  logic [63:0] sreg_rsp_data;
  logic        dsm_wr_valid;
  logic [63:0] dsm_wr_addr;
  logic [63:0] dsm_wr_data;
  logic        dsm_wr_ready;
  logic        dsm_base_valid;
  logic        busy;
  logic        drop_flag;
  logic        timeout_flag;

  int total  = 0;
  int passed = 0;

  // Transaction-level model state
  logic [63:0] m_base;
  bit          m_base_valid;
  bit          m_drop;
  bit          m_tflag;

  qa_driver_sreg_ctrl #(.SREG_TIMEOUT(TO), .DSM_SREG_OFFSET(OFF)) dut (
    .clk(clk), .reset(reset),
    .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .sreg_req_valid(sreg_req_valid), .sreg_req_addr(sreg_req_addr), .sreg_req_ready(sreg_req_ready),
    .sreg_rsp_valid(sreg_rsp_valid), .sreg_rsp_data(sreg_rsp_data),
    .dsm_wr_valid(dsm_wr_valid), .dsm_wr_addr(dsm_wr_addr), .dsm_wr_data(dsm_wr_data),
    .dsm_wr_ready(dsm_wr_ready), .dsm_base_valid(dsm_base_valid),
    .busy(busy), .drop_flag(drop_flag), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [15:0] a, input logic [63:0] d, input bit idle);
    csr_wr_valid = 1'b1; csr_wr_addr = a; csr_wr_data = d;
    tick();
    csr_wr_valid = 1'b0;
    if (a == 16'h1a00) begin
      m_base = d; m_base_valid = 1'b1;
    end else if (a == 16'h1a10 && !(idle && m_base_valid)) begin
      m_drop = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_valid"}, sreg_req_valid, 0);
    check({tag, "_req_addr"},  sreg_req_addr,  0);
    check({tag, "_wr_valid"},  dsm_wr_valid,   0);
    check({tag, "_wr_addr"},   dsm_wr_addr,    0);
    check({tag, "_wr_data"},   dsm_wr_data,    0);
    check({tag, "_base_v"},    dsm_base_valid, 0);
    check({tag, "_busy"},      busy,           0);
    check({tag, "_drop"},      drop_flag,      0);
    check({tag, "_tflag"},     timeout_flag,   0);
  endtask

  // One full read: request, response, DSM write, with optional disturbances.
  task automatic do_txn(input logic [31:0] idx, input int req_dly, input int rsp_dly,
                        input int wr_dly, input logic [63:0] rsp, input bit stray,
                        input bit inj_drop, input bit inj_base, input bit inj_race);
    logic [63:0] exp_a;
    exp_a = m_base + OFF;
    csr(16'h1a10, {$urandom, idx}, 1'b1);
    check("req_valid", sreg_req_valid, 1);
    check("req_addr", sreg_req_addr, idx);
    check("busy_req", busy, 1);
    repeat (req_dly) begin
      sreg_rsp_valid = stray; sreg_rsp_data = {$urandom, $urandom};
      tick();
    end
    sreg_rsp_valid = 1'b0;
    check("req_hold", {sreg_req_valid, sreg_req_addr}, {1'b1, idx});
    sreg_req_ready = 1'b1;
    tick();
    sreg_req_ready = 1'b0;
    check("req_done", sreg_req_valid, 0);
    if (inj_drop) csr(16'h1a10, {$urandom, $urandom}, 1'b0);
    if (inj_base) csr(16'h1a00, {$urandom, $urandom}, 1'b0);
    repeat (rsp_dly) tick();
    check("wait_no_wr", dsm_wr_valid, 0);
    sreg_rsp_valid = 1'b1; sreg_rsp_data = rsp;
    tick();
    sreg_rsp_valid = 1'b0;
    check("wr_valid", dsm_wr_valid, 1);
    check("wr_addr", dsm_wr_addr, exp_a);
    check("wr_data", dsm_wr_data, rsp);
    repeat (wr_dly) begin
      sreg_rsp_valid = 1'($urandom); sreg_rsp_data = {$urandom, $urandom};
      tick();
    end
    sreg_rsp_valid = 1'b0;
    check("wr_hold_v", dsm_wr_valid, 1);
    check("wr_hold_a", dsm_wr_addr, exp_a);
    check("wr_hold_d", dsm_wr_data, rsp);
    dsm_wr_ready = 1'b1;
    if (inj_race) begin
      csr_wr_valid = 1'b1; csr_wr_addr = 16'h1a10; csr_wr_data = {$urandom, $urandom};
      m_drop = 1'b1;
    end
    tick();
    dsm_wr_ready = 1'b0; csr_wr_valid = 1'b0;
    check("wr_done", dsm_wr_valid, 0);
    check("idle_busy", busy, 0);
    check("drop", drop_flag, m_drop);
    check("tflag", timeout_flag, m_tflag);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    csr_wr_valid = 0; csr_wr_addr = 0; csr_wr_data = 0;
    sreg_req_ready = 0; sreg_rsp_valid = 0; sreg_rsp_data = 0; dsm_wr_ready = 0;
    m_base = 0; m_base_valid = 0; m_drop = 0; m_tflag = 0;
    tick(); tick();
    check_zero("rst");
    reset = 1'b0;
    tick();

    // Request before any base: dropped, nothing issued
    csr(16'h1a10, 64'h5, 1'b1);
    check("nobase_req", sreg_req_valid, 0);
    check("nobase_busy", busy, 0);
    check("nobase_drop", drop_flag, 1);

    // Reset clears the sticky drop; then the reference transaction
    reset = 1'b1; tick(); reset = 1'b0; m_drop = 0;
    check("rst2_drop", drop_flag, 0);
    csr(16'h1a14, 64'h7, 1'b1);
    check("ign_busy", busy, 0);
    check("ign_base_v", dsm_base_valid, 0);
    csr(16'h1a00, 64'h1000, 1'b1);
    check("base_v", dsm_base_valid, 1);
    do_txn(32'h5, 0, 2, 0, 64'hABCD, 0, 0, 0, 0);

    // Drop in WAIT plus base rewrite; then slow write-ready
    do_txn(32'h9, 1, 1, 0, 64'h1234, 0, 1, 0, 0);
    m_base = m_base; // base unchanged so far
    do_txn(32'h11, 0, 0, 5, 64'h55AA, 1, 0, 1, 1);
    check("base_after", 64'(m_base_valid), 1);

    // Randomized transactions
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) csr(16'h1a00, {$urandom, $urandom}, 1'b1);
      do_txn($urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
             {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

`ifdef QA_SREG_TIMEOUT_EN
    // Response on the last allowed WAIT cycle wins over the timeout
    csr(16'h1a10, 64'h21, 1'b1);
    sreg_req_ready = 1'b1; tick(); sreg_req_ready = 1'b0;
    repeat (TO - 1) tick();
    sreg_rsp_valid = 1'b1; sreg_rsp_data = 64'hCAFE;
    tick();
    sreg_rsp_valid = 1'b0;
    check("race_data", dsm_wr_data, 64'hCAFE);
    check("race_tflag", timeout_flag, 0);
    dsm_wr_ready = 1'b1; tick(); dsm_wr_ready = 1'b0;

    // No response: all-ones result after TO WAIT cycles
    csr(16'h1a10, 64'h22, 1'b1);
    sreg_req_ready = 1'b1; tick(); sreg_req_ready = 1'b0;
    n = 0;
    while (!dsm_wr_valid && n < 40) begin tick(); n++; end
    check("to_cycles", n, TO);
    check("to_data", dsm_wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_addr", dsm_wr_addr, m_base + OFF);
    check("to_tflag", timeout_flag, 1);
    m_tflag = 1;
    dsm_wr_ready = 1'b1; tick(); dsm_wr_ready = 1'b0;
    check("to_idle", busy, 0);
`else
    // Without timeout support WAIT never expires on its own
    csr(16'h1a10, 64'h22, 1'b1);
    sreg_req_ready = 1'b1; tick(); sreg_req_ready = 1'b0;
    n = 0;
    while (!dsm_wr_valid && n < 40) begin tick(); n++; end
    check("noto_wait", n, 40);
    check("noto_busy", busy, 1);
    sreg_rsp_valid = 1'b1; sreg_rsp_data = 64'h77; tick(); sreg_rsp_valid = 1'b0;
    check("noto_data", dsm_wr_data, 64'h77);
    check("noto_tflag", timeout_flag, 0);
    dsm_wr_ready = 1'b1; tick(); dsm_wr_ready = 1'b0;
`endif

    // Reset during WAIT aborts the read with no DSM write
    csr(16'h1a10, 64'h33, 1'b1);
    sreg_req_ready = 1'b1; tick(); sreg_req_ready = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check_zero("arst");
    tick();
    reset = 1'b0;
    m_base_valid = 0; m_drop = 0; m_tflag = 0;
    sreg_rsp_valid = 1'b1; sreg_rsp_data = 64'hDEAD; tick(); sreg_rsp_valid = 1'b0;
    tick();
    check_zero("post");
    csr(16'h1a10, 64'h44, 1'b1);
    check("post_req", sreg_req_valid, 0);
    check("post_drop", drop_flag, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qa_driver_sreg_ctrl.md
QA_DRIVER_SREG_CTRL -- requirements
Module: qa_driver_sreg_ctrl

Interface
REQ-001 Parameter SREG_TIMEOUT, default 1024, WAIT-state cycle limit before abandoning a status-register read; legal range 2..65535.
REQ-002 Parameter DSM_SREG_OFFSET, default 64'h40, byte offset added to the DSM base for the result write.
REQ-003 clk  in  1  single block clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 csr_wr_valid  in  1  CSR write strobe, one cycle per write.
REQ-006 csr_wr_addr  in  16  CSR byte address.
REQ-007 csr_wr_data  in  64  CSR write data.
REQ-008 sreg_req_valid  out  1  status-register read request to FPGA-side client.
REQ-009 sreg_req_addr  out  32  status-register index.
REQ-010 sreg_req_ready  in  1  client accepts request.
REQ-011 sreg_rsp_valid  in  1  client response strobe.
REQ-012 sreg_rsp_data  in  64  client response value.
REQ-013 dsm_wr_valid  out  1  DSM result write request.
REQ-014 dsm_wr_addr  out  64  DSM byte address of the result.
REQ-015 dsm_wr_data  out  64  result value.
REQ-016 dsm_wr_ready  in  1  DSM write accepted.
REQ-017 dsm_base_valid  out  1  DSM base programmed.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 drop_flag  out  1  sticky; a read request was discarded.
REQ-020 timeout_flag  out  1  sticky; a read timed out (0 when timeout support is compiled out).

Function
REQ-021 Write to address 16'h1a00: dsm_base <= csr_wr_data and dsm_base_valid <= 1, in any state.
REQ-022 Write to address 16'h1a10 in IDLE with dsm_base_valid=1: latch csr_wr_data[31:0] as sreg_req_addr, latch dsm_base, go to REQ.
REQ-023 Write to address 16'h1a10 when not IDLE or with dsm_base_valid=0: discard the request and set drop_flag.
REQ-024 Writes to all other addresses, including 16'h1a14, are ignored.
REQ-025 States are IDLE, REQ, WAIT and WRITE; the only transitions are IDLE->REQ, REQ->WAIT, WAIT->WRITE and WRITE->IDLE.
REQ-026 REQ: sreg_req_valid=1 with stable sreg_req_addr; on sreg_req_ready=1 go to WAIT.
REQ-027 Request latency: a 1a10 write sampled in cycle N gives sreg_req_valid=1 in cycle N+1.
REQ-028 WAIT: on sreg_rsp_valid=1 capture sreg_rsp_data and go to WRITE.
REQ-029 sreg_rsp_valid in any state other than WAIT is ignored.
REQ-030 WRITE: dsm_wr_valid=1, dsm_wr_addr = latched base + DSM_SREG_OFFSET (64-bit, modulo 2^64), dsm_wr_data = captured value.
REQ-031 WRITE outputs are held stable until dsm_wr_ready=1, then the block returns to IDLE.
REQ-032 Response latency: sreg_rsp_valid in cycle M gives dsm_wr_valid=1 in cycle M+1.
REQ-033 A DSM base write during a transaction does not alter the in-flight dsm_wr_addr.
REQ-034 A 1a10 write in the same cycle as the WRITE->IDLE handshake is dropped, because the state is not IDLE when sampled.
REQ-035 Simultaneous 1a00 and 1a10 writes are impossible (single write port); a 1a10 write in the cycle after a 1a00 write is accepted.

Reset
REQ-036 Reset forces state to IDLE immediately, including mid-transaction; the aborted read produces no DSM write.
REQ-037 During and after reset all outputs are 0: dsm_base, dsm_base_valid, busy, drop_flag, timeout_flag, sreg_req_valid, sreg_req_addr, dsm_wr_valid, dsm_wr_addr and dsm_wr_data.

Configuration
REQ-038 With QA_SREG_TIMEOUT_EN defined, a 16-bit counter clears on WAIT entry and increments each WAIT cycle.
REQ-039 With QA_SREG_TIMEOUT_EN defined and the counter at SREG_TIMEOUT-1 with no response, the block goes to WRITE with data 64'hFFFF_FFFF_FFFF_FFFF and sets timeout_flag.
REQ-040 With QA_SREG_TIMEOUT_EN defined, a response arriving in the same cycle as timeout wins: the response data is written and timeout_flag is unchanged.
REQ-041 Without QA_SREG_TIMEOUT_EN, WAIT persists until a response arrives, no counter exists, and timeout_flag is tied to 0.

Verification
REQ-042 Write 1a00=64'h1000, then 1a10=32'h5; ready immediately; response 64'hABCD two cycles later -> one DSM write, addr 64'h1040, data 64'hABCD, one cycle after the response.
REQ-043 Write 1a10 before any 1a00 -> no sreg_req_valid, drop_flag=1, busy stays 0.
REQ-044 Second 1a10 write while in WAIT, then 1a00=64'h2000 -> second request dropped (drop_flag=1), DSM address remains the original base + 64'h40.
REQ-045 With QA_SREG_TIMEOUT_EN and SREG_TIMEOUT=8, no response -> DSM write of all-ones exactly 8 WAIT cycles after WAIT entry, timeout_flag=1.
REQ-046 Assert reset during WAIT, then send a response -> no DSM write, all outputs 0, dsm_base_valid=0.
REQ-047 Hold dsm_wr_ready=0 for 5 cycles in WRITE -> dsm_wr_addr and dsm_wr_data stable throughout, return to IDLE the cycle after ready=1.
